// File: rtl/mult_switch_feeder.sv
// Feeds a multiplier switch: one stationary beat per job, then exactly len
// streaming beats drained in order from a small input FIFO.
module mult_switch_feeder #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              i_cfg_valid,
  input  logic [DATA_W-1:0] i_cfg_stat,
  input  logic [LEN_W-1:0]  i_cfg_len,
  output logic              o_cfg_ready,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_stationary,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] stat_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  acc_q;
  logic [LEN_W-1:0]  sent_q;
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              valid_q;
  logic              stationary_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;

  logic fifo_empty;
  logic fifo_full;
  logic ready;
  logic push;
  logic pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    ready      = ((state_q == S_LOAD) || (state_q == S_STREAM)) &&
                 !fifo_full && (acc_q < len_q);
    push       = i_valid && ready;
    pop        = (state_q == S_STREAM) && !fifo_empty;
  end

  assign o_cfg_ready  = (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_ready      = ready;
  assign o_valid      = valid_q;
  assign o_stationary = stationary_q;
  assign o_data       = data_q;
  assign o_done       = done_q;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      stat_q       <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      sent_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      valid_q      <= 1'b0;
      stationary_q <= 1'b0;
      data_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) begin
        wptr_q <= wptr_q + PTR_ONE;
        acc_q  <= acc_q + LEN_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
        sent_q <= sent_q + LEN_ONE;
      end
      case (state_q)
        S_IDLE: begin
          valid_q      <= 1'b0;
          stationary_q <= 1'b0;
          if (i_cfg_valid) begin
            stat_q  <= i_cfg_stat;
            len_q   <= i_cfg_len;
            acc_q   <= '0;
            sent_q  <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          valid_q      <= 1'b1;
          stationary_q <= 1'b1;
          data_q       <= stat_q;
          state_q      <= (len_q != '0) ? S_STREAM : S_DONE;
        end
        S_STREAM: begin
          valid_q      <= pop;
          stationary_q <= 1'b0;
          if (pop) begin
            data_q <= mem_q[rptr_q[AW-1:0]];
            if ((sent_q + LEN_ONE) == len_q) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // The pulse registers here, so it is seen in the cycle after DONE.
          valid_q      <= 1'b0;
          stationary_q <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_switch_feeder.sv
// Directed bench for mult_switch_feeder: cycle tables for short jobs and a
// small scoreboard for longer streaming jobs.
module tb_mult_switch_feeder;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        i_cfg_valid;
  logic [15:0] i_cfg_stat;
  logic [7:0]  i_cfg_len;
  logic        o_cfg_ready;
  logic        i_valid;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_stationary;
  logic        o_busy;
  logic        o_done;

  mult_switch_feeder #(.DATA_W(16), .LEN_W(8), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .i_cfg_valid(i_cfg_valid), .i_cfg_stat(i_cfg_stat), .i_cfg_len(i_cfg_len),
    .o_cfg_ready(o_cfg_ready),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .o_stationary(o_stationary),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] src_q[$];
  logic [15:0] cap_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] stat_val;
  int          nstat, jacc, jstrm, jdone, gap_cnt;
  bit          gapped;

  // Cycle tables for the basic job, sampled on the falling edge after each rise.
  int          t_valid [7] = '{0, 1, 1, 1, 1, 0, 0};
  int          t_stat  [7] = '{0, 1, 0, 0, 0, 0, 0};
  int          t_done  [7] = '{0, 0, 0, 0, 0, 1, 0};
  int          t_cfgr  [7] = '{0, 0, 0, 0, 0, 1, 1};
  int          t_ready [7] = '{1, 1, 1, 0, 0, 0, 0};
  int          t_busy  [7] = '{1, 1, 1, 1, 1, 0, 0};
  logic [15:0] t_data  [7] = '{16'h0000, 16'h3F80, 16'h4000, 16'h4040,
                               16'h4080, 16'h4080, 16'h4080};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic upd();
    i_valid = (src_q.size() != 0) && (gap_cnt == 0);
    i_data  = (src_q.size() != 0) ? src_q[0] : 16'h0;
  endtask

  // One clock: note whether the upcoming edge handshakes, then log outputs.
  task automatic step();
    bit acc_now;
    acc_now = i_valid && o_ready;
    @(posedge CLK);
    @(negedge CLK);
    if (acc_now) begin
      src_q.delete(0);
      jacc++;
    end
    if (o_valid) begin
      if (o_stationary) begin
        nstat++;
        stat_val = o_data;
      end else begin
        cap_q.push_back(o_data);
        jstrm++;
      end
    end
    if (o_done) jdone++;
    if (gap_cnt > 0) gap_cnt--;
    upd();
  endtask

  task automatic clr_job();
    jacc = 0; jstrm = 0; jdone = 0; nstat = 0; gapped = 0; gap_cnt = 0;
    cap_q.delete();
  endtask

  task automatic run_job(input string tag, input logic [15:0] stat,
                         input logic [7:0] len, input int gap_at);
    clr_job();
    i_cfg_valid = 1'b1; i_cfg_stat = stat; i_cfg_len = len;
    upd();
    step();
    i_cfg_valid = 1'b0;
    check({tag, "_accepted"}, o_busy, 1);
    for (int unsigned c = 0; c < 80 && jdone == 0; c++) begin
      check({tag, "_ready"}, o_ready,
            (o_busy && ((jacc - jstrm) < 4) && (jacc < int'(len))) ? 1 : 0);
      if (gap_at != 0 && jacc == gap_at && !gapped) begin
        gapped = 1; gap_cnt = 3; upd();
      end
      step();
    end
    check({tag, "_done_seen"}, jdone, 1);
    step();
    check({tag, "_done_pulse"}, o_done, 0);
    check({tag, "_nstat"}, nstat, 1);
    check({tag, "_stat_val"}, stat_val, stat);
    check({tag, "_nbeats"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      check({tag, "_beat"}, cap_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_cfg_valid = 1'b0; i_cfg_stat = '0; i_cfg_len = '0;
    i_valid = 1'b0; i_data = '0;
    clr_job();
    repeat (2) @(negedge CLK);
    check("rst_valid", o_valid, 0);
    check("rst_stat", o_stationary, 0);
    check("rst_data", o_data, 0);
    check("rst_done", o_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cfgr", o_cfg_ready, 1);
    check("rst_ready", o_ready, 0);
    rst_n = 1'b1;
    @(negedge CLK);

    // Basic job, cycle accurate.
    clr_job();
    src_q = '{16'h4000, 16'h4040, 16'h4080};
    i_cfg_valid = 1'b1; i_cfg_stat = 16'h3F80; i_cfg_len = 8'd3;
    upd();
    for (int k = 0; k < 7; k++) begin
      step();
      i_cfg_valid = 1'b0;
      check("basic_valid", o_valid, t_valid[k]);
      check("basic_stat", o_stationary, t_stat[k]);
      check("basic_data", o_data, t_data[k]);
      check("basic_done", o_done, t_done[k]);
      check("basic_cfgr", o_cfg_ready, t_cfgr[k]);
      check("basic_ready", o_ready, t_ready[k]);
      check("basic_busy", o_busy, t_busy[k]);
    end

    // Zero length: stationary beat only, upstream element left untouched.
    clr_job();
    src_q = '{16'hAAAA};
    i_cfg_valid = 1'b1; i_cfg_stat = 16'h1111; i_cfg_len = 8'd0;
    upd();
    step(); i_cfg_valid = 1'b0;
    check("zl_n1_valid", o_valid, 0);
    check("zl_n1_ready", o_ready, 0);
    step();
    check("zl_n2_valid", o_valid, 1);
    check("zl_n2_stat", o_stationary, 1);
    check("zl_n2_data", o_data, 16'h1111);
    check("zl_n2_ready", o_ready, 0);
    step();
    check("zl_n3_done", o_done, 1);
    check("zl_n3_valid", o_valid, 0);
    check("zl_n3_ready", o_ready, 0);
    step();
    check("zl_n4_done", o_done, 0);
    check("zl_unconsumed", src_q.size(), 1);
    src_q.delete(); upd();

    // len=10 with a 3-cycle upstream gap; pointers wrap twice.
    src_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      src_q.push_back(16'h5000 + 16'(i));
      exp_q.push_back(16'h5000 + 16'(i));
    end
    run_job("wrap", 16'h3C00, 8'd10, 5);

    // Over-offer: 6 offered, only 4 taken.
    src_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(16'h6000 + 16'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h6000 + 16'(i));
    run_job("over", 16'h4200, 8'd4, 0);
    check("over_left", src_q.size(), 2);
    if (src_q.size() != 0) check("over_next", src_q[0], 16'h6004);
    src_q.delete(); upd();

    // Reset after the 2nd streaming beat of a len=5 job.
    clr_job();
    for (int i = 0; i < 5; i++) src_q.push_back(16'h7000 + 16'(i));
    i_cfg_valid = 1'b1; i_cfg_stat = 16'h4400; i_cfg_len = 8'd5;
    upd();
    step(); i_cfg_valid = 1'b0;
    for (int unsigned c = 0; c < 20 && jstrm < 2; c++) step();
    check("rstm_reached", jstrm, 2);
    check("rstm_beat2", o_data, 16'h7001);
    #1 rst_n = 1'b0;
    #1;
    check("rstm_valid", o_valid, 0);
    check("rstm_stat", o_stationary, 0);
    check("rstm_data", o_data, 0);
    check("rstm_busy", o_busy, 0);
    check("rstm_done", o_done, 0);
    src_q.delete(); gap_cnt = 0; upd();
    step(); step();
    check("rstm_no_done", jdone, 0);
    check("rstm_no_beats", jstrm, 2);
    rst_n = 1'b1;
    src_q = '{16'hBEEF};
    exp_q = '{16'hBEEF};
    run_job("post_rst", 16'h1234, 8'd1, 0);

    // Cfg held high across a job: second job starts after o_done.
    clr_job();
    src_q = '{16'h3333};
    i_cfg_valid = 1'b1; i_cfg_stat = 16'h2222; i_cfg_len = 8'd1;
    upd();
    step();
    check("busy_n1_busy", o_busy, 1);
    check("busy_n1_cfgr", o_cfg_ready, 0);
    i_cfg_stat = 16'h4444; i_cfg_len = 8'd0;
    step();
    check("busy_n2_stat", o_stationary, 1);
    check("busy_n2_data", o_data, 16'h2222);
    step();
    check("busy_n3_valid", o_valid, 1);
    check("busy_n3_data", o_data, 16'h3333);
    check("busy_n3_done", o_done, 0);
    step();
    check("busy_n4_done", o_done, 1);
    check("busy_n4_valid", o_valid, 0);
    check("busy_n4_cfgr", o_cfg_ready, 1);
    step();
    check("busy_n5_busy", o_busy, 1);
    check("busy_n5_valid", o_valid, 0);
    i_cfg_valid = 1'b0;
    step();
    check("busy_n6_valid", o_valid, 1);
    check("busy_n6_stat", o_stationary, 1);
    check("busy_n6_data", o_data, 16'h4444);
    step();
    check("busy_n7_done", o_done, 1);
    check("busy_nstat", nstat, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_switch_feeder.md
MULT_SWITCH_FEEDER -- requirements
Module: mult_switch_feeder

Interface
REQ-001 Parameter: DATA_W, default 16, element width (BF16).
REQ-002 Parameter: LEN_W, default 8, stream-length counter width.
REQ-003 Parameter: FIFO_DEPTH, default 4, input FIFO entries, power of 2.
REQ-004 Port: CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: i_cfg_valid  in  1  job request.
REQ-007 Port: i_cfg_stat  in  DATA_W  stationary value for the job.
REQ-008 Port: i_cfg_len  in  LEN_W  number of streaming elements; 0 is legal.
REQ-009 Port: o_cfg_ready  out  1  job accepted when high together with i_cfg_valid.
REQ-010 Port: i_valid  in  1  upstream streaming element valid.
REQ-011 Port: i_data  in  DATA_W  upstream streaming element.
REQ-012 Port: o_ready  out  1  upstream element accepted when high together with i_valid.
REQ-013 Port: o_valid  out  1  beat valid to the multiplier switch.
REQ-014 Port: o_data  out  DATA_W  beat data to the multiplier switch.
REQ-015 Port: o_stationary  out  1  beat is the stationary value, latched by the switch.
REQ-016 Port: o_busy  out  1  high in any state other than IDLE.
REQ-017 Port: o_done  out  1  one-cycle pulse when a job completes.

Function
REQ-018 FSM states: IDLE, LOAD, STREAM, DONE.
REQ-019 o_cfg_ready SHALL be high only in IDLE.
REQ-020 IDLE: on i_cfg_valid, latch i_cfg_stat and i_cfg_len, clear the accepted and sent counters, and go to LOAD.
REQ-021 LOAD, single cycle:
- At the next edge, the output registers load o_valid=1, o_stationary=1, o_data=stat.
- Go to STREAM if len>0, otherwise go to DONE.
REQ-022 o_ready SHALL be (state is LOAD or STREAM) AND FIFO not full AND accepted<len.
- o_ready SHALL NOT depend on a same-cycle pop.
REQ-023 Upstream handshake: i_valid&&o_ready at an edge pushes i_data and increments the accepted count.
REQ-024 STREAM, at each edge:
- FIFO non-empty: pop the head into the output registers (o_valid=1, o_stationary=0, o_data=head) and increment the sent count.
- FIFO empty: o_valid=0.
REQ-025 STREAM exit: when the pop that makes sent==len occurs, go to DONE at that edge.
REQ-026 DONE: o_done=1 for exactly one cycle, then return to IDLE; o_valid=0 while in DONE.
REQ-027 In IDLE and DONE, o_valid=0 and o_stationary=0; o_data holds its last value.
REQ-028 A push and a pop in the same cycle SHALL both take effect; FIFO occupancy is unchanged.
REQ-029 FIFO read and write pointers wrap modulo FIFO_DEPTH.
- Occupancy is tracked with one extra bit so that full and empty are distinguished.
REQ-030 Upstream data is never dropped, duplicated or reordered.
- Exactly len elements are accepted per job.
- Exactly len streaming beats, in acceptance order, follow the single stationary beat.
REQ-031 i_valid/i_data SHALL be ignored while o_ready=0; i_cfg_valid SHALL be ignored outside IDLE.
REQ-032 Latency: first streaming beat on o_valid no earlier than one cycle after its push; stationary beat one cycle after cfg acceptance.

Reset
REQ-033 rst_n=0 SHALL immediately, regardless of clock:
- force the state to IDLE;
- empty the FIFO and clear the pointers and counters;
- set o_valid=0, o_stationary=0, o_data=0, o_done=0.
REQ-034 Reset asserted mid-job SHALL abort the job with no further beats.
- After release, the block accepts a new job in IDLE on the first clock edge.

Verification
REQ-035 Basic job: cfg stat=0x3F80, len=3; upstream 0x4000, 0x4040, 0x4080 back-to-back -> output beats (stat=1, 0x3F80), (0, 0x4000), (0, 0x4040), (0, 0x4080), then o_done one cycle, then o_cfg_ready=1.
REQ-036 Zero length: cfg len=0 -> one stationary beat, o_done the next cycle, o_ready never high.
REQ-037 Full FIFO / wrap-around: len=10, upstream always valid; a downstream-idle-free run plus an injected 3-cycle upstream gap -> all 10 beats in order, pointers wrap, o_ready low exactly while 4 entries are held or accepted==10.
REQ-038 Over-offer: upstream offers 6 elements for len=4 -> only the first 4 are accepted (o_ready drops after the 4th); elements 5 and 6 are not consumed.
REQ-039 Reset mid-stream: assert rst_n=0 after the 2nd streaming beat of a len=5 job -> outputs zero asynchronously, no o_done; a new job (stat=0x1234, len=1) after release completes normally.
REQ-040 Cfg during busy: i_cfg_valid held high through a job -> the second job starts only after o_done, and its stationary beat appears two cycles after the o_done cycle.
